// File: rtl/shift_frame_pkg.sv
`default_nettype none
// ============================================================================
// Module   : shift_frame_pkg
// Purpose  : Shared constants and the state encoding for the serial frame receiver.
// Revision : 1.0  initial release
// ============================================================================
package shift_frame_pkg;

    localparam int c_DEFAULT_LENGTH = 4;

    localparam logic c_START_BIT = 1'b0;
    localparam logic c_STOP_BIT  = 1'b1;

    typedef enum logic [1:0] {
        S_IDLE   = 2'd0,
        S_DATA   = 2'd1,
        S_PARITY = 2'd2,
        S_STOP   = 2'd3
    } state_t;

endpackage : shift_frame_pkg
`default_nettype wire

// File: rtl/rx_shift_reg.sv
`default_nettype none
// ============================================================================
// Module   : rx_shift_reg
// Purpose  : LENGTH-bit serial-in shift-left register with enable and a
//            synchronous active-low clear.
// Revision : 1.0  initial release
// ============================================================================
module rx_shift_reg
    import shift_frame_pkg::*;
#(
    parameter int LENGTH = c_DEFAULT_LENGTH
) (
    input  logic              CLOCK,
    input  logic              _CLR,
    input  logic              EN,
    input  logic              DIN,
    output logic [LENGTH-1:0] Q
);

    logic [LENGTH-1:0] r_sreg;

    always_ff @(posedge CLOCK) begin
        if (!_CLR) begin
            r_sreg <= '0;
        end else if (EN) begin
            r_sreg <= {r_sreg[LENGTH-2:0], DIN};
        end
    end

    assign Q = r_sreg;

endmodule : rx_shift_reg
`default_nettype wire

// File: rtl/shift_frame_rx.sv
`default_nettype none
// ============================================================================
// Module   : shift_frame_rx
// Purpose  : Receives start/data/even-parity/stop frames (MSB first) and
//            presents each word on a buffered valid/ready parallel output.
// Revision : 1.0  initial release
// ============================================================================
module shift_frame_rx
    import shift_frame_pkg::*;
#(
    parameter int LENGTH = c_DEFAULT_LENGTH
) (
    input  logic              CLOCK,
    input  logic              _MR,
    input  logic              DIN,
    input  logic              BIT_EN,
    input  logic              READY,
    output logic [LENGTH-1:0] DATA,
    output logic              VALID,
    output logic              PERR,
    output logic              FERR,
    output logic              OVERRUN,
    output logic              BUSY
);

    localparam int                c_CNT_W = $clog2(LENGTH + 1);
    localparam logic [c_CNT_W-1:0] c_LAST_BIT = c_CNT_W'(LENGTH - 1);

    state_t              r_state;
    state_t              w_next_state;
    logic [c_CNT_W-1:0]  r_cnt;
    logic                r_acc;
    logic                r_perr_pend;
    logic                w_shift_en;
    logic                w_commit;
    logic                w_xfer;
    logic [LENGTH-1:0]   w_sreg;

    logic [LENGTH-1:0]   r_data;
    logic                r_valid;
    logic                r_perr;
    logic                r_ferr;
    logic                r_overrun;
    logic                r_busy;

    rx_shift_reg #(
        .LENGTH (LENGTH)
    ) u_sreg (
        .CLOCK (CLOCK),
        ._CLR  (_MR),
        .EN    (w_shift_en),
        .DIN   (DIN),
        .Q     (w_sreg)
    );

    always_ff @(posedge CLOCK) begin
        if (!_MR) begin
            r_state <= S_IDLE;
        end else begin
            r_state <= w_next_state;
        end
    end

    // Every transition is gated by BIT_EN; without a strobe nothing moves.
    always_comb begin
        w_next_state = r_state;
        w_shift_en   = 1'b0;
        w_commit     = 1'b0;
        if (BIT_EN) begin
            case (r_state)
                S_IDLE: begin
                    if (DIN == c_START_BIT) begin
                        w_next_state = S_DATA;
                    end
                end
                S_DATA: begin
                    w_shift_en = 1'b1;
                    if (r_cnt == c_LAST_BIT) begin
                        w_next_state = S_PARITY;
                    end
                end
                S_PARITY: begin
                    w_next_state = S_STOP;
                end
                S_STOP: begin
                    w_commit     = 1'b1;
                    w_next_state = S_IDLE;
                end
                default: begin
                    w_next_state = S_IDLE;
                end
            endcase
        end
    end

    always_ff @(posedge CLOCK) begin
        if (!_MR) begin
            r_cnt       <= '0;
            r_acc       <= 1'b0;
            r_perr_pend <= 1'b0;
        end else if (BIT_EN) begin
            case (r_state)
                S_IDLE: begin
                    r_cnt <= '0;
                    r_acc <= 1'b0;
                end
                S_DATA: begin
                    r_cnt <= r_cnt + 1'b1;
                    r_acc <= r_acc ^ DIN;
                end
                S_PARITY: begin
                    r_perr_pend <= r_acc ^ DIN;
                end
                default: begin
                    r_cnt <= r_cnt;
                end
            endcase
        end
    end

    assign w_xfer = r_valid & READY;

    // A commit in the same cycle as a transfer refills the buffer, so VALID stays high.
    always_ff @(posedge CLOCK) begin
        if (!_MR) begin
            r_data    <= '0;
            r_valid   <= 1'b0;
            r_perr    <= 1'b0;
            r_ferr    <= 1'b0;
            r_overrun <= 1'b0;
            r_busy    <= 1'b0;
        end else begin
            r_busy <= (w_next_state != S_IDLE);
            if (w_xfer) begin
                r_valid <= 1'b0;
            end
            if (w_commit) begin
                if (!r_valid || READY) begin
                    r_data  <= w_sreg;
                    r_perr  <= r_perr_pend;
                    r_ferr  <= (DIN != c_STOP_BIT);
                    r_valid <= 1'b1;
                end else begin
                    r_overrun <= 1'b1;
                end
            end
        end
    end

    assign DATA    = r_data;
    assign VALID   = r_valid;
    assign PERR    = r_perr;
    assign FERR    = r_ferr;
    assign OVERRUN = r_overrun;
    assign BUSY    = r_busy;

endmodule : shift_frame_rx
`default_nettype wire

// File: tb/tb_shift_frame_rx.sv
`default_nettype none
// ============================================================================
// Module   : tb_shift_frame_rx
// Purpose  : Directed vector bench for shift_frame_rx with LENGTH=4.
// Revision : 1.0  initial release
// ============================================================================
module tb_shift_frame_rx;

    localparam int LENGTH = 4;

    logic              CLOCK = 1'b0;
    logic              _MR   = 1'b0;
    logic              DIN   = 1'b1;
    logic              BIT_EN = 1'b0;
    logic              READY = 1'b1;
    logic [LENGTH-1:0] DATA;
    logic              VALID;
    logic              PERR;
    logic              FERR;
    logic              OVERRUN;
    logic              BUSY;

    int n_vec  = 0;
    int n_fail = 0;

    typedef struct {
        logic [6:0]  bits;   // bits[6] is sent first (start bit)
        int          gap;    // idle cycles with BIT_EN=0 before each strobe
        logic [3:0]  d;
        logic        p;
        logic        f;
    } vec_t;

    vec_t vecs[8];

    shift_frame_rx #(.LENGTH(LENGTH)) dut (
        .CLOCK   (CLOCK),
        ._MR     (_MR),
        .DIN     (DIN),
        .BIT_EN  (BIT_EN),
        .READY   (READY),
        .DATA    (DATA),
        .VALID   (VALID),
        .PERR    (PERR),
        .FERR    (FERR),
        .OVERRUN (OVERRUN),
        .BUSY    (BUSY)
    );

    always #5 CLOCK = ~CLOCK;

    task automatic chk(input string name, input logic [31:0] act, input logic [31:0] exp);
        n_vec++;
        if (act !== exp) begin
            n_fail++;
            $display("FAIL %s: got %0h, expected %0h", name, act, exp);
        end
    endtask

    // Drives one bit for exactly one BIT_EN cycle; returns on the negedge after the sampling edge.
    task automatic strobe(input logic b, input int gap);
        repeat (gap) @(negedge CLOCK);
        @(negedge CLOCK);
        DIN    = b;
        BIT_EN = 1'b1;
        @(negedge CLOCK);
        BIT_EN = 1'b0;
        DIN    = 1'b1;
    endtask

    task automatic send(input logic [6:0] bits, input int gap);
        for (int i = 6; i >= 0; i--) begin
            strobe(bits[i], gap);
        end
    endtask

    initial begin
        vecs[0] = '{7'b0101111, 0, 4'b1011, 1'b0, 1'b0};  // clean
        vecs[1] = '{7'b0101101, 0, 4'b1011, 1'b1, 1'b0};  // parity error
        vecs[2] = '{7'b0011000, 0, 4'b0110, 1'b0, 1'b1};  // framing error
        vecs[3] = '{7'b0000001, 0, 4'b0000, 1'b0, 1'b0};  // all zeros
        vecs[4] = '{7'b0111101, 0, 4'b1111, 1'b0, 1'b0};  // all ones
        vecs[5] = '{7'b0100011, 0, 4'b1000, 1'b0, 1'b0};  // MSB only
        vecs[6] = '{7'b0001001, 0, 4'b0010, 1'b1, 1'b0};  // parity error, even data
        vecs[7] = '{7'b0101111, 2, 4'b1011, 1'b0, 1'b0};  // clean frame with BIT_EN gaps

        // Reset state
        repeat (2) @(negedge CLOCK);
        chk("rst_valid", VALID, 0);
        chk("rst_busy", BUSY, 0);
        chk("rst_data", DATA, 0);
        chk("rst_overrun", OVERRUN, 0);
        _MR = 1'b1;

        for (int v = 0; v < 8; v++) begin
            strobe(vecs[v].bits[6], vecs[v].gap);
            chk($sformatf("v%0d_busy_start", v), BUSY, 1);
            for (int i = 5; i >= 0; i--) begin
                strobe(vecs[v].bits[i], vecs[v].gap);
            end
            chk($sformatf("v%0d_valid", v), VALID, 1);
            chk($sformatf("v%0d_data", v), DATA, vecs[v].d);
            chk($sformatf("v%0d_perr", v), PERR, vecs[v].p);
            chk($sformatf("v%0d_ferr", v), FERR, vecs[v].f);
            chk($sformatf("v%0d_busy_end", v), BUSY, 0);
            @(negedge CLOCK);
            chk($sformatf("v%0d_valid_drop", v), VALID, 0);
        end

        // Idle line: no start bit, nothing happens
        for (int i = 0; i < 20; i++) begin
            strobe(1'b1, 0);
        end
        chk("idle_busy", BUSY, 0);
        chk("idle_valid", VALID, 0);

        // Overrun: second frame dropped while the first is unconsumed
        READY = 1'b0;
        send(7'b0101111, 0);
        chk("ovr_first_valid", VALID, 1);
        chk("ovr_first_overrun", OVERRUN, 0);
        send(7'b0011001, 0);
        chk("ovr_data_held", DATA, 4'b1011);
        chk("ovr_valid", VALID, 1);
        chk("ovr_flag", OVERRUN, 1);
        chk("ovr_perr", PERR, 0);
        chk("ovr_ferr", FERR, 0);
        READY = 1'b1;
        @(negedge CLOCK);
        chk("ovr_valid_drop", VALID, 0);
        chk("ovr_sticky", OVERRUN, 1);

        // Reset mid-frame after two data bits
        strobe(1'b0, 0);
        strobe(1'b1, 0);
        strobe(1'b0, 0);
        chk("mid_busy_before", BUSY, 1);
        _MR = 1'b0;
        @(negedge CLOCK);
        chk("mid_busy", BUSY, 0);
        chk("mid_valid", VALID, 0);
        chk("mid_data", DATA, 0);
        chk("mid_perr", PERR, 0);
        chk("mid_ferr", FERR, 0);
        chk("mid_overrun", OVERRUN, 0);
        _MR = 1'b1;
        send(7'b0011001, 0);
        chk("post_rst_valid", VALID, 1);
        chk("post_rst_data", DATA, 4'b0110);
        chk("post_rst_perr", PERR, 0);
        chk("post_rst_ferr", FERR, 0);

        $display("== %0d vectors applied, %0d miscompares ==", n_vec, n_fail);
        $finish;
    end

endmodule : tb_shift_frame_rx
`default_nettype wire

// File: doc/shift_frame_rx.md
# shift_frame_rx

Serial-in, parallel-out frame receiver. It is the receiving end of the MSB-first serial stream that our 4-bit universal shift register emits in shift-left mode. It detects a start bit, shifts in LENGTH data bits, checks even parity and the stop bit, then presents the word on a buffered parallel output with a valid/ready handshake. It sits between the serial link and the parallel consumer logic.

## Interface
- LENGTH, 4, data bits per frame (≥2)
- CLOCK  input  1  system clock, rising edge
- _MR  input  1  reset: synchronous, active-low
- DIN  input  1  serial line; idles high
- BIT_EN  input  1  bit strobe; DIN is sampled only in cycles with BIT_EN=1
- READY  input  1  consumer accepts DATA this cycle
- DATA  output  LENGTH  received word, MSB = first data bit received
- VALID  output  1  DATA holds an unconsumed word
- PERR  output  1  parity error flag for the word in DATA
- FERR  output  1  stop-bit (framing) error flag for the word in DATA
- OVERRUN  output  1  sticky: a completed frame was dropped
- BUSY  output  1  a frame is in progress (state ≠ IDLE)

## Operation
- Frame format: start bit 0, then LENGTH data bits MSB first, then one even-parity bit (total count of ones over data+parity is even), then stop bit 1.
- FSM states: IDLE, DATA, PARITY, STOP. Transitions occur only in cycles with BIT_EN=1; with BIT_EN=0 all state is held.
- IDLE: DIN=0 → DATA; clear bit counter and parity accumulator. DIN=1 → stay in IDLE.
- DATA: shift register ← {sreg[LENGTH-2:0], DIN}; accumulator ^= DIN; counter +1. After LENGTH bits → PARITY. Counter width is clog2(LENGTH+1).
- PARITY: perr_pend ← accumulator ^ DIN; → STOP.
- STOP: commit the frame, then → IDLE regardless of DIN. A bad stop bit does not abort the frame: the word is delivered with FERR=1.
- Commit, when VALID=0 or READY=1: DATA←sreg, PERR←perr_pend, FERR←~DIN, VALID←1.
- Commit, when VALID=1 and READY=0: frame dropped, DATA/PERR/FERR unchanged, OVERRUN←1.
- Handshake: a transfer happens on VALID&READY. After a transfer VALID←0, unless a commit occurs in the same cycle, in which case VALID stays 1 with the new word. READY is ignored while VALID=0.
- OVERRUN is cleared only by reset.
- Reset (_MR=0 at a clock edge): state IDLE, sreg=0, counter=0, DATA=0, VALID=0, PERR=0, FERR=0, OVERRUN=0, BUSY=0. Reset asserted mid-frame discards the partial frame. _MR overrides all other inputs.

## Timing
- All outputs are registered.
- VALID rises in the cycle after the clock edge that samples the stop bit (one-cycle latency from the stop-bit BIT_EN).
- BUSY rises the cycle after the start-bit sample and falls the cycle after the stop-bit sample.
- Minimum frame duration: LENGTH+3 BIT_EN strobes. Back-to-back frames are allowed: a start bit may be sampled on the very next BIT_EN after the stop bit.
- DATA, PERR and FERR are stable for as long as VALID=1 and READY=0.

## Structure
- Shared package shift_frame_pkg holds:
  - the state encoding constants (IDLE=0, DATA=1, PARITY=2, STOP=3);
  - the default LENGTH;
  - the constants START_BIT=0 and STOP_BIT=1.
- One sub-module is natural: rx_shift_reg. It is a LENGTH-bit serial-in shift-left register with an enable input and a synchronous active-low clear. The FSM, counter, parity logic and output buffer stay in the top module.

## Test plan
All scenarios use LENGTH=4.
- Clean frame: bits 0,1,0,1,1,1,1 with READY=1 → DATA=4'b1011, VALID=1 for one cycle, PERR=0, FERR=0.
- Parity error: bits 0,1,0,1,1,0,1 → DATA=4'b1011, PERR=1, FERR=0.
- Framing error: bits 0,0,1,1,0,0,0 → DATA=4'b0110, PERR=0, FERR=1, FSM back in IDLE.
- Overrun: READY=0; send 1011 (parity 1), then 0110 (parity 0) → DATA stays 4'b1011, VALID=1, OVERRUN=1. Then raise READY → VALID=0 next cycle; OVERRUN stays 1.
- Reset mid-frame: assert _MR=0 after two data bits → BUSY=0 and all outputs 0 on the next edge. A subsequent clean 0110 frame yields DATA=4'b0110 with no error flags.
- Idle and gating: DIN=1 with 20 BIT_EN strobes → BUSY and VALID stay 0. A valid frame whose strobes are interleaved with BIT_EN=0 gaps decodes the same as the ungapped frame.
